// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the port-B arbiter of the 64 KB dual-port BRAM.
// Contents:
//   DefAddrW / DefDataW : address and data widths matching ram_64kb
//   arb_state_e         : access sequencer states
package bram_arb_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
// Ports:
//   req_i   : request vector
//   start_i : index searched first; the search wraps upward modulo NUM_REQ
//   idx_o   : winning index (0 when nothing requests)
//   valid_o : at least one request present
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Rotate so that bit 0 of rot is the start requester.
  logic [NUM_REQ-1:0] rot;
  assign rot = NUM_REQ'({req_i, req_i} >> start_i);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && rot[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'((int'(start_i) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbiter and access sequencer for data port B of the 64 KB dual-port BRAM.
// One granted access at a time runs IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> DONE.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_req/i_we/i_lock       : per-requester request, write enable, keep-priority
//   i_addr/i_wdata          : packed per-requester address / write data
//   o_gnt, o_ack            : one-hot grant (ISSUE..DONE), one-cycle ack in DONE
//   o_rdata                 : data of the most recent completed read
//   o_busy                  : sequencer not idle
//   o_bram_*/i_bram_dout    : BRAM port B
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_we,
  input  logic [NUM_REQ-1:0]         i_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  i_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  i_wdata,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic [DATA_W-1:0]          o_rdata,
  output logic                       o_busy,
  output logic                       o_bram_we,
  output logic [ADDR_W-1:0]          o_bram_addr,
  output logic [DATA_W-1:0]          o_bram_din,
  input  logic [DATA_W-1:0]          i_bram_dout
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LatW  = $clog2(RD_LAT + 1);
  localparam int unsigned LockW = $clog2(MAX_LOCK + 1);
  // lock_cnt_q counts locked re-grants beyond the first grant of a run, so a run of
  // consecutive grants to one requester never exceeds MAX_LOCK.
  localparam logic [LockW-1:0] LockLimit = LockW'(MAX_LOCK - 1);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  gnt_q, ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                bram_we_q;
  logic [ADDR_W-1:0]   bram_addr_q;
  logic [DATA_W-1:0]   bram_din_q;
  logic [IdxW-1:0]     idx_q;
  logic [IdxW-1:0]     last_q;
  logic                lock_armed_q;
  logic [LockW-1:0]    lock_cnt_q;
  logic [LatW-1:0]     wait_cnt_q;

  logic [IdxW-1:0]     start_idx, pick_idx, win_idx;
  logic                pick_valid, lock_win, win_valid;
  logic [NUM_REQ-1:0]  win_oh;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic                we_sel;

  assign start_idx = (last_q == IdxW'(NUM_REQ - 1)) ? '0 : last_q + IdxW'(1);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_pick (
    .req_i   (i_req),
    .start_i (start_idx),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // An armed lock only wins if its owner is still requesting; otherwise it is forfeited.
  assign lock_win  = lock_armed_q && i_req[idx_q];
  assign win_idx   = lock_win ? idx_q : pick_idx;
  assign win_valid = lock_win || pick_valid;

  always_comb begin
    win_oh    = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IdxW'(k) == win_idx) begin
        win_oh[k] = 1'b1;
        addr_sel  = i_addr[k*ADDR_W +: ADDR_W];
        wdata_sel = i_wdata[k*DATA_W +: DATA_W];
        we_sel    = i_we[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
      idx_q        <= '0;
      last_q       <= IdxW'(NUM_REQ - 1);
      lock_armed_q <= 1'b0;
      lock_cnt_q   <= '0;
      wait_cnt_q   <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          gnt_q        <= '0;
          lock_armed_q <= 1'b0;
          lock_cnt_q   <= lock_win ? lock_cnt_q + LockW'(1) : '0;
          if (win_valid) begin
            // The BRAM registers double as the access latches.
            idx_q       <= win_idx;
            gnt_q       <= win_oh;
            bram_addr_q <= addr_sel;
            bram_din_q  <= wdata_sel;
            bram_we_q   <= we_sel;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          bram_we_q  <= 1'b0;
          wait_cnt_q <= LatW'(RD_LAT - 1);
          if (bram_we_q) begin
            ack_q   <= gnt_q;
            state_q <= StDone;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == '0) begin
            rdata_q <= i_bram_dout;
            ack_q   <= gnt_q;
            state_q <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q - LatW'(1);
          end
        end
        StDone: begin
          gnt_q   <= '0;
          last_q  <= idx_q;
          state_q <= StIdle;
          if (i_lock[idx_q] && (lock_cnt_q < LockLimit)) begin
            lock_armed_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_gnt       = gnt_q;
  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = (state_q != StIdle);
  assign o_bram_we   = bram_we_q;
  assign o_bram_addr = bram_addr_q;
  assign o_bram_din  = bram_din_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios followed by random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_bram_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RL = 1;
  localparam int ML = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req, we, lock;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    o_gnt, o_ack;
  logic [DW-1:0]    o_rdata;
  logic             o_busy;
  logic             bram_we;
  logic [AW-1:0]    bram_addr;
  logic [DW-1:0]    bram_din;
  logic [DW-1:0]    bram_dout = '0;

  int n_total = 0;
  int n_bad   = 0;

  bram_port_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RD_LAT   (RL),
    .MAX_LOCK (ML)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_we        (we),
    .i_lock      (lock),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_gnt       (o_gnt),
    .o_ack       (o_ack),
    .o_rdata     (o_rdata),
    .o_busy      (o_busy),
    .o_bram_we   (bram_we),
    .o_bram_addr (bram_addr),
    .o_bram_din  (bram_din),
    .i_bram_dout (bram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Port-B BRAM, read-first, one cycle read latency; unwritten cells read init_val.
  logic [7:0] mem [0:65535];
  bit         wr  [0:65535];
  always @(posedge clk) begin
    if (bram_we) begin
      mem[bram_addr] <= bram_din;
      wr[bram_addr]  <= 1'b1;
    end
    bram_dout <= wr[bram_addr] ? mem[bram_addr] : init_val(bram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit w, input logic [15:0] a, input logic [7:0] d,
                         input bit l);
    req[k]            = 1'b1;
    we[k]             = w;
    lock[k]           = l;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    req  = '0;
    we   = '0;
    lock = '0;
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(o_gnt),     32'd0);
    chk({tag, "_ack"},   32'(o_ack),     32'd0);
    chk({tag, "_rdata"}, 32'(o_rdata),   32'd0);
    chk({tag, "_busy"},  32'(o_busy),    32'd0);
    chk({tag, "_we"},    32'(bram_we),   32'd0);
    chk({tag, "_addr"},  32'(bram_addr), 32'd0);
    chk({tag, "_din"},   32'(bram_din),  32'd0);
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Directed-scenario bookkeeping
  int            ack_cyc[$];
  int            ack_idx[$];
  int            grants[$];
  int            exp_cyc[3] = '{3, 7, 11};
  int            exp_lock[5] = '{0, 0, 1, 0, 0};
  logic [NR-1:0] drop, prev_gnt;

  // Reference model state (transaction level)
  int         m_last, m_holder, m_run;
  int         cur_k, g_start, ack_c, winner;
  bit         cur_we, cur_lock, in_win;
  logic [7:0] cur_data, exp_rdata;
  logic [NR-1:0] exp_g, exp_a;
  bit         pend[NR];
  bit         p_we[NR];
  bit         p_lock[NR];
  logic [15:0] p_addr[NR];
  logic [7:0]  p_wd[NR];
  int          retire;
  logic [7:0]  mem_m [int];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;
    tick();
    tick();
    chk_all_zero("reset");
    #2 rst_n = 1'b1;

    // Single write
    tick();
    set_req(1, 1'b1, 16'h1234, 8'hA5, 1'b0);
    chk("wr_idle_gnt", 32'(o_gnt), 32'd0);
    tick();
    chk("wr_gnt",  32'(o_gnt),     32'(3'b010));
    chk("wr_we",   32'(bram_we),   32'd1);
    chk("wr_addr", 32'(bram_addr), 32'h1234);
    chk("wr_din",  32'(bram_din),  32'hA5);
    chk("wr_ack0", 32'(o_ack),     32'd0);
    chk("wr_busy", 32'(o_busy),    32'd1);
    tick();
    chk("wr_ack",  32'(o_ack),     32'(3'b010));
    chk("wr_gnt2", 32'(o_gnt),     32'(3'b010));
    chk("wr_we2",  32'(bram_we),   32'd0);
    tick();
    req = '0;
    chk("wr_ack_end", 32'(o_ack),  32'd0);
    chk("wr_gnt_end", 32'(o_gnt),  32'd0);
    chk("wr_idle",    32'(o_busy), 32'd0);

    // Read-back
    set_req(1, 1'b0, 16'h1234, 8'h00, 1'b0);
    tick();
    chk("rd_gnt",  32'(o_gnt),     32'(3'b010));
    chk("rd_we",   32'(bram_we),   32'd0);
    chk("rd_addr", 32'(bram_addr), 32'h1234);
    tick();
    chk("rd_ack0", 32'(o_ack),     32'd0);
    chk("rd_we2",  32'(bram_we),   32'd0);
    tick();
    chk("rd_ack",   32'(o_ack),   32'(3'b010));
    chk("rd_rdata", 32'(o_rdata), 32'hA5);
    tick();
    req = '0;
    chk("rd_ack_end", 32'(o_ack),   32'd0);
    chk("rd_hold",    32'(o_rdata), 32'hA5);

    // Contention: three reads from reset
    apply_reset();
    tick();
    for (int k = 0; k < NR; k++) set_req(k, 1'b0, 16'h0010 + 16'(k), 8'h00, 1'b0);
    drop = '0;
    for (int t = 1; t <= 13; t++) begin
      tick();
      req  = req & ~drop;
      drop = '0;
      chk("cont_onehot", 32'($onehot0(o_gnt)), 32'd1);
      if (o_ack != '0) begin
        ack_cyc.push_back(t);
        ack_idx.push_back(oh2i(o_ack));
        chk("cont_rdata", 32'(o_rdata), 32'(init_val(16'h0010 + 16'(oh2i(o_ack)))));
        drop = o_ack;
      end
    end
    chk("cont_nack", 32'(ack_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < ack_cyc.size()) begin
        chk("cont_cycle", 32'(ack_cyc[i]), 32'(exp_cyc[i]));
        chk("cont_order", 32'(ack_idx[i]), 32'(i));
      end
    end

    // Lock with MAX_LOCK = 2
    apply_reset();
    tick();
    set_req(0, 1'b1, 16'h0020, 8'h11, 1'b1);
    set_req(1, 1'b1, 16'h0021, 8'h22, 1'b0);
    drop     = '0;
    prev_gnt = '0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      req  = req & ~drop;
      drop = '0;
      if (o_gnt != '0 && prev_gnt == '0) grants.push_back(oh2i(o_gnt));
      prev_gnt = o_gnt;
      if (o_ack[1]) drop = 3'b010;
    end
    chk("lock_ngrant", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) chk("lock_order", 32'(grants[i]), 32'(exp_lock[i]));
    end
    req  = '0;
    lock = '0;
    repeat (4) tick();

    // Async reset during WAIT
    apply_reset();
    tick();
    set_req(0, 1'b0, 16'h0030, 8'h00, 1'b0);
    tick();
    tick();
    chk("ar_busy", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("ar");
    req = '0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("ar_noack", 32'(o_ack), 32'd0);
    end
    set_req(2, 1'b0, 16'h0032, 8'h00, 1'b0);
    tick();
    chk("ar_gnt", 32'(o_gnt), 32'(3'b100));
    tick();
    tick();
    chk("ar_ack",   32'(o_ack),   32'(3'b100));
    chk("ar_rdata", 32'(o_rdata), 32'(init_val(16'h0032)));
    tick();
    req = '0;
    chk("ar_gnt_end", 32'(o_gnt), 32'd0);

    // Early drop of req during ISSUE
    set_req(2, 1'b1, 16'h0040, 8'h3C, 1'b0);
    tick();
    chk("ed_gnt", 32'(o_gnt),   32'(3'b100));
    chk("ed_we",  32'(bram_we), 32'd1);
    req[2] = 1'b0;
    tick();
    chk("ed_ack", 32'(o_ack), 32'(3'b100));
    tick();
    chk("ed_ack_end", 32'(o_ack),  32'd0);
    chk("ed_idle",    32'(o_busy), 32'd0);

    // Random traffic against the reference model
    apply_reset();
    m_last    = NR - 1;
    m_holder  = -1;
    m_run     = 0;
    cur_k     = -1;
    g_start   = 0;
    ack_c     = -1;
    exp_rdata = '0;
    retire    = -1;
    for (int k = 0; k < NR; k++) pend[k] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      in_win = (cur_k >= 0) && (c >= g_start) && (c <= ack_c);
      exp_g  = in_win ? NR'(1 << cur_k) : '0;
      exp_a  = (cur_k >= 0 && c == ack_c) ? exp_g : '0;
      if (cur_k >= 0 && c == ack_c && !cur_we) exp_rdata = cur_data;
      chk("rnd_gnt",   32'(o_gnt),   32'(exp_g));
      chk("rnd_ack",   32'(o_ack),   32'(exp_a));
      chk("rnd_busy",  32'(o_busy),  32'(exp_g != '0));
      chk("rnd_rdata", 32'(o_rdata), 32'(exp_rdata));

      // Completion: rotation point and lock decision; requester drops next cycle.
      if (cur_k >= 0 && c == ack_c) begin
        m_last   = cur_k;
        m_holder = (cur_lock && m_run < ML) ? cur_k : -1;
        retire   = cur_k;
      end else if (retire >= 0) begin
        pend[retire] = 1'b0;
        retire       = -1;
      end

      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && $urandom_range(2) == 0) begin
          pend[k]   = 1'b1;
          p_we[k]   = 1'($urandom_range(1));
          p_addr[k] = 16'h0100 + 16'($urandom_range(15));
          p_wd[k]   = 8'($urandom);
          p_lock[k] = ($urandom_range(3) == 0);
        end
      end
      for (int k = 0; k < NR; k++) begin
        req[k]            = pend[k];
        we[k]             = p_we[k];
        lock[k]           = p_lock[k];
        addr[k*AW +: AW]  = p_addr[k];
        wdata[k*DW +: DW] = p_wd[k];
      end

      // Arbitration happens only when the previous access has fully finished.
      if (c > ack_c) begin
        winner = -1;
        if (m_holder >= 0 && pend[m_holder]) begin
          winner = m_holder;
          m_run++;
        end else begin
          for (int i = 1; i <= NR; i++) begin
            if (winner < 0 && pend[(m_last + i) % NR]) winner = (m_last + i) % NR;
          end
          m_run = 1;
        end
        m_holder = -1;
        if (winner >= 0) begin
          cur_k    = winner;
          cur_we   = p_we[winner];
          cur_lock = p_lock[winner];
          g_start  = c + 1;
          ack_c    = c + 2 + (cur_we ? 0 : RL);
          if (cur_we) begin
            mem_m[int'(p_addr[winner])] = p_wd[winner];
          end else begin
            cur_data = mem_m.exists(int'(p_addr[winner])) ? mem_m[int'(p_addr[winner])]
                                                         : init_val(p_addr[winner]);
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
